// File: rtl/float_to_int_param.sv
// Parametrised IEEE-754 float to signed integer converter with stb/ack handshakes,
// truncate / round-nearest-even rounding, saturation and {invalid, overflow, inexact} flags.
module float_to_int_param #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  parameter  int INT_W = 32,
  localparam int F_W   = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [F_W-1:0]   input_a,
  input  logic             input_a_stb,
  output logic             input_a_ack,
  input  logic             round_mode,
  output logic [INT_W-1:0] output_z,
  output logic             output_z_stb,
  input  logic             output_z_ack,
  output logic [2:0]       output_flags
);

  localparam int BIAS = 2**(EXP_W-1) - 1;
  // Magnitude register must hold 1.f unshifted and any in-range integer plus a carry bit.
  localparam int MW   = ((INT_W > MAN_W + 1) ? INT_W : MAN_W + 1) + 1;
  localparam int CW   = $clog2(MAN_W + 2) + 1;
  localparam logic [INT_W-1:0] MAX_V = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] MIN_V = {1'b1, {(INT_W-1){1'b0}}};

  typedef enum logic [2:0] {GET_A, UNPACK, SPECIAL, ALIGN, ROUND, PACK, PUT_Z} state_t;

  state_t           state;
  logic [F_W-1:0]   a_r;
  logic             rnd_r;
  logic [MW-1:0]    mag;
  logic             guard, sticky;
  logic [CW-1:0]    cnt;
  logic [INT_W-1:0] z_r;
  logic [2:0]       flags_r;

  logic             s_c;
  logic [EXP_W-1:0] ef_c;
  logic [MAN_W-1:0] f_c;
  int               e_c;
  logic             is_special;
  logic [INT_W-1:0] spec_z;
  logic [2:0]       spec_f;
  logic [MW-1:0]    mag_init;
  logic [CW-1:0]    cnt_init;
  logic             inc;
  logic [MW-1:0]    mag_rnd;
  logic             rnd_ovf;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    s_c        = a_r[F_W-1];
    ef_c       = a_r[F_W-2:MAN_W];
    f_c        = a_r[MAN_W-1:0];
    e_c        = int'(ef_c) - BIAS;
    is_special = 1'b1;
    spec_z     = '0;
    spec_f     = '0;
    if (&ef_c) begin
      if (|f_c) begin
        spec_z = MIN_V;
        spec_f = 3'b100;
      end else begin
        spec_z = s_c ? MIN_V : MAX_V;
        spec_f = 3'b010;
      end
    end else if (ef_c == '0) begin
      spec_f = {2'b00, |f_c};
    end else if (e_c < -1) begin
      spec_f = 3'b001;
    end else if (e_c > INT_W - 1 || (e_c == INT_W - 1 && !(s_c && f_c == '0))) begin
      spec_z = s_c ? MIN_V : MAX_V;
      spec_f = 3'b010;
    end else if (e_c == INT_W - 1) begin
      spec_z = MIN_V;
    end else begin
      is_special = 1'b0;
    end

    // Large exponents need no right shifts: place the hidden bit with one left shift.
    if (e_c >= MAN_W) begin
      mag_init = MW'({1'b1, f_c}) << (e_c - MAN_W);
      cnt_init = '0;
    end else begin
      mag_init = MW'({1'b1, f_c});
      cnt_init = CW'(MAN_W - e_c);
    end

    inc     = rnd_r & guard & (sticky | mag[0]);
    mag_rnd = mag + MW'(inc);
    rnd_ovf = !s_c && (mag_rnd >= MW'(MIN_V));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= GET_A;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= '0;
      output_flags <= '0;
      a_r          <= '0;
      rnd_r        <= 1'b0;
      mag          <= '0;
      guard        <= 1'b0;
      sticky       <= 1'b0;
      cnt          <= '0;
      z_r          <= '0;
      flags_r      <= '0;
    end else begin
      case (state)
        GET_A: begin
          input_a_ack <= 1'b1;
          if (input_a_ack && input_a_stb) begin
            a_r         <= input_a;
            rnd_r       <= round_mode;
            input_a_ack <= 1'b0;
            state       <= UNPACK;
          end
        end
        UNPACK: begin
          mag     <= mag_init;
          cnt     <= cnt_init;
          guard   <= 1'b0;
          sticky  <= 1'b0;
          z_r     <= spec_z;
          flags_r <= spec_f;
          state   <= is_special ? SPECIAL : ALIGN;
        end
        SPECIAL: begin
          output_z     <= z_r;
          output_flags <= flags_r;
          state        <= PUT_Z;
        end
        ALIGN: begin
          if (cnt == '0) begin
            state <= ROUND;
          end else begin
            mag    <= mag >> 1;
            guard  <= mag[0];
            sticky <= sticky | guard;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= ROUND;
          end
        end
        ROUND: begin
          mag     <= rnd_ovf ? MW'(MAX_V) : mag_rnd;
          flags_r <= {1'b0, rnd_ovf, guard | sticky};
          state   <= PACK;
        end
        PACK: begin
          // A negative result of magnitude 2^(INT_W-1) negates to MIN in INT_W bits.
          output_z     <= s_c ? -mag[INT_W-1:0] : mag[INT_W-1:0];
          output_flags <= flags_r;
          state        <= PUT_Z;
        end
        PUT_Z: begin
          output_z_stb <= 1'b1;
          if (output_z_stb && output_z_ack) begin
            output_z_stb <= 1'b0;
            state        <= GET_A;
          end
        end
        default: state <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_int_param.sv
// Scoreboard bench for float_to_int_param: a single-precision and a double-precision
// instance share clk/rst; expected results are queued at send time and popped on output.
module tb_float_to_int_param;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [31:0] a32 = '0;
  logic        stb32 = 1'b0, rm32 = 1'b0, zack32 = 1'b1;
  logic        ack32, zstb32;
  logic [31:0] z32;
  logic [2:0]  f32;

  logic [63:0] a64 = '0;
  logic        stb64 = 1'b0, rm64 = 1'b0, zack64 = 1'b1;
  logic        ack64, zstb64;
  logic [63:0] z64;
  logic [2:0]  f64;

  typedef struct {
    logic [63:0] z;
    logic [2:0]  f;
    string       tag;
  } exp_t;

  exp_t sb32[$];
  exp_t sb64[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  float_to_int_param dut32 (
    .clk(clk), .rst(rst),
    .input_a(a32), .input_a_stb(stb32), .input_a_ack(ack32), .round_mode(rm32),
    .output_z(z32), .output_z_stb(zstb32), .output_z_ack(zack32), .output_flags(f32)
  );

  float_to_int_param #(.EXP_W(11), .MAN_W(52), .INT_W(64)) dut64 (
    .clk(clk), .rst(rst),
    .input_a(a64), .input_a_stb(stb64), .input_a_ack(ack64), .round_mode(rm64),
    .output_z(z64), .output_z_stb(zstb64), .output_z_ack(zack64), .output_flags(f64)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon32
    exp_t e;
    if (!rst && zstb32 && zack32) begin
      if (sb32.size() == 0) begin
        check("sb32_unexpected_output", 64'(sb32.size()), 64'd1);
      end else begin
        e = sb32.pop_front();
        check({e.tag, "_z"}, 64'(z32), e.z);
        check({e.tag, "_flags"}, 64'(f32), 64'(e.f));
      end
    end
  end

  always @(negedge clk) begin : mon64
    exp_t e;
    if (!rst && zstb64 && zack64) begin
      if (sb64.size() == 0) begin
        check("sb64_unexpected_output", 64'(sb64.size()), 64'd1);
      end else begin
        e = sb64.pop_front();
        check({e.tag, "_z"}, z64, e.z);
        check({e.tag, "_flags"}, 64'(f64), 64'(e.f));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input bit wide, input logic [63:0] a, input bit rm,
                      input logic [63:0] ez, input logic [2:0] ef, input string tag);
    exp_t e;
    bit   seen;
    e.z = ez;
    e.f = ef;
    e.tag = tag;
    if (wide) begin
      sb64.push_back(e);
      a64 = a; rm64 = rm; stb64 = 1'b1;
    end else begin
      sb32.push_back(e);
      a32 = a[31:0]; rm32 = rm; stb32 = 1'b1;
    end
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = wide ? ack64 : ack32;
    end
    @(posedge clk);
    #1;
    stb32 = 1'b0;
    stb64 = 1'b0;
    check({tag, "_accepted"}, 64'(seen), 64'd1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && (sb32.size() != 0 || sb64.size() != 0); i++) @(posedge clk);
    @(posedge clk);
    #1;
    check({tag, "_drained"}, 64'(sb32.size() + sb64.size()), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 64'(ack32), 64'd0);
    check("rst_zstb", 64'(zstb32), 64'd0);
    check("rst_z", 64'(z32), 64'd0);
    check("rst_flags", 64'(f32), 64'd0);
    rst = 1'b0;
    #1;
    check("ack_before_edge", 64'(ack32), 64'd0);
    @(posedge clk);
    #1;
    check("ack_after_edge", 64'(ack32), 64'd1);

    // Single precision, back-to-back with output_z_ack held high
    send(0, 64'h4049_0FDB, 0, 64'h0000_0003, 3'b001, "pi_trunc");
    send(0, 64'h4049_0FDB, 1, 64'h0000_0003, 3'b001, "pi_rne");
    send(0, 64'h3FC0_0000, 1, 64'h0000_0002, 3'b001, "p1_5_rne");
    send(0, 64'h4020_0000, 1, 64'h0000_0002, 3'b001, "p2_5_rne");
    send(0, 64'hC020_0000, 1, 64'hFFFF_FFFE, 3'b001, "m2_5_rne");
    send(0, 64'h4020_0000, 0, 64'h0000_0002, 3'b001, "p2_5_trunc");
    send(0, 64'h4060_0000, 1, 64'h0000_0004, 3'b001, "p3_5_rne");
    send(0, 64'h3FE0_0000, 0, 64'h0000_0001, 3'b001, "p1_75_trunc");
    send(0, 64'hBFE0_0000, 1, 64'hFFFF_FFFE, 3'b001, "m1_75_rne");
    send(0, 64'h3F40_0000, 1, 64'h0000_0001, 3'b001, "p0_75_rne");
    send(0, 64'h4B00_0001, 0, 64'h0080_0001, 3'b000, "e_eq_man");
    send(0, 64'h4B80_0001, 0, 64'h0100_0002, 3'b000, "e_gt_man");
    send(0, 64'h4EFF_FFFF, 1, 64'h7FFF_FF80, 3'b000, "largest_in_range");
    send(0, 64'h4F00_0000, 0, 64'h7FFF_FFFF, 3'b010, "p2_31");
    send(0, 64'hCF00_0000, 0, 64'h8000_0000, 3'b000, "m2_31");
    send(0, 64'h3F00_0000, 1, 64'h0000_0000, 3'b001, "half_rne");
    send(0, 64'h0000_0001, 1, 64'h0000_0000, 3'b001, "denormal");
    send(0, 64'h8000_0000, 1, 64'h0000_0000, 3'b000, "neg_zero");
    send(0, 64'h7FC0_0000, 0, 64'h8000_0000, 3'b100, "nan");
    send(0, 64'h7F80_0000, 0, 64'h7FFF_FFFF, 3'b010, "pos_inf");
    send(0, 64'hFF80_0000, 0, 64'h8000_0000, 3'b010, "neg_inf");
    drain("sp_batch");

    // Result held while output_z_ack stays low
    zack32 = 1'b0;
    send(0, 64'hC049_0FDB, 0, 64'hFFFF_FFFD, 3'b001, "mpi_hold");
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = zstb32;
    end
    check("hold_stb_seen", 64'(seen), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_stb", 64'(zstb32), 64'd1);
      check("hold_z", 64'(z32), 64'h0000_0000_FFFF_FFFD);
      check("hold_flags", 64'(f32), 64'd1);
      check("hold_in_ack", 64'(ack32), 64'd0);
    end
    @(posedge clk);
    #1;
    zack32 = 1'b1;
    drain("hold");

    // Reset in the middle of ALIGN discards the conversion
    send(0, 64'h3F00_0000, 1, 64'h0000_0000, 3'b001, "aborted");
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    void'(sb32.pop_back());
    check("abort_in_ack", 64'(ack32), 64'd0);
    check("abort_zstb", 64'(zstb32), 64'd0);
    check("abort_z", 64'(z32), 64'd0);
    check("abort_flags", 64'(f32), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(0, 64'h4020_0000, 0, 64'h0000_0002, 3'b001, "after_abort");
    drain("abort");

    // Double precision instance
    send(1, 64'h4340_0000_0000_0001, 0, 64'h0020_0000_0000_0002, 3'b000, "dp_big_exact");
    send(1, 64'h3FF8_0000_0000_0000, 1, 64'h0000_0000_0000_0002, 3'b001, "dp_1_5_rne");
    send(1, 64'hBFF8_0000_0000_0000, 0, 64'hFFFF_FFFF_FFFF_FFFF, 3'b001, "dp_m1_5_trunc");
    send(1, 64'h43E0_0000_0000_0000, 0, 64'h7FFF_FFFF_FFFF_FFFF, 3'b010, "dp_p2_63");
    send(1, 64'hC3E0_0000_0000_0000, 0, 64'h8000_0000_0000_0000, 3'b000, "dp_m2_63");
    drain("dp_batch");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
